rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between core
//  writeback and the matrix-MAC result stream.
//  - Core writeback has priority and zero-latency pass-through.
//  - MAC results are buffered in a small FIFO and drained on idle write cycles.
//  - A 32-bit pending scoreboard lets the hazard unit see registers awaiting
//    MAC results.
//  - A starvation counter requests a core stall so queued MAC results drain.
// PARAMETERS
//  DEPTH         4   MAC result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   consecutive non-empty, un-popped cycles before core_stall
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous reset, active-low
//  core_we      in   1   core writeback valid
//  core_rd      in   5   core destination register
//  core_wd      in   32  core write data
//  mac_valid    in   1   MAC result offered
//  mac_rd       in   5   MAC destination register
//  mac_wd       in   32  MAC result data
//  mac_ready    out  1   MAC result accepted this cycle when mac_valid&mac_ready
//  rf_we        out  1   to register file WE3
//  rf_a3        out  5   to register file A3
//  rf_wd        out  32  to register file WD3
//  rd_pending   out  32  bit n=1: a live MAC write to xn is queued
//  fifo_count   out  $clog2(DEPTH)+1  occupied entries, live or squashed
//  core_stall   out  1   registered request to the hazard unit to hold the core
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//   - FIFO emptied, rd_pending=0, starve counter=0, core_stall=0.
//   - While rst=0: rf_we=0, mac_ready=0.
//  mac_ready (combinational)
//   - Equals rst & (fifo_count<DEPTH) & ~rd_pending[mac_rd].
//   - A duplicate destination is refused until the older entry pops.
//  Enqueue (mac_valid & mac_ready)
//   - mac_rd=0: accepted and discarded; nothing stored.
//   - Otherwise the entry is stored live and rd_pending[mac_rd] is set at the next edge.
//  Grant (combinational, same cycle)
//   1. core_stall=1 and FIFO non-empty: pop head. A core_we this cycle is
//      ignored; it is a protocol violation.
//   2. Else core_we=1: core wins.
//      - rf_we=(core_rd!=0), rf_a3=core_rd, rf_wd=core_wd.
//   3. Else FIFO non-empty: pop head.
//      - rf_we=head.live, rf_a3=head.rd, rf_wd=head.wd.
//   4. Else rf_we=0, rf_a3=0, rf_wd=0.
//   - Latency: core write reaches the RF in 0 cycles; a MAC entry needs at
//     least 1 cycle (enqueue edge, then pop).
//  Pop
//   - Head advances at the next edge.
//   - rd_pending[head.rd] is cleared if the entry was live.
//  WAW squash
//   - A granted core write to xn with rd_pending[n]=1 clears head-or-later
//     entry n's live bit and rd_pending[n] at the edge.
//   - That entry later pops with rf_we=0, so the newer core value survives.
//  Simultaneous enqueue+pop: fifo_count unchanged; pointers wrap modulo DEPTH.
//  Starve counter
//   - Increments each cycle the FIFO is non-empty without a pop.
//   - Clears on any pop or when the FIFO is empty; saturates at STARVE_LIMIT.
//  core_stall
//   - Set at the edge where the counter reaches STARVE_LIMIT.
//   - Cleared at the edge after the FIFO becomes empty.
//  Reset mid-operation: queued entries are dropped; no RF write is issued.
// TESTING
//  1 Core only: core_we=1,rd=5,wd=0xA5 -> same cycle rf_we=1,rf_a3=5,rf_wd=0xA5; rd=0 -> rf_we=0.
//  2 MAC drain: enqueue x6=0x10, x7=0x20 with core idle -> RF writes x6 then x7 in consecutive cycles; rd_pending bits 6/7 set then cleared; fifo_count 0.
//  3 Full/dup: fill 4 distinct rds with core_we held high -> mac_ready=0 at count=4; offer a rd already pending -> mac_ready=0 until it pops.
//  4 Starvation: 1 entry queued, core_we=1 every cycle -> core_stall=1 after 8 cycles; entry written next cycle; core_stall=0 the cycle after.
//  5 WAW: queue x9=0x1, then core writes x9=0x2 -> rd_pending[9] clears; MAC pop gives rf_we=0; x9 ends at 0x2.
//  6 Reset mid-op: 3 entries queued, rst=0 one cycle -> fifo_count=0, rd_pending=0, core_stall=0, no rf_we afterwards.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between core writeback (priority, zero latency)
// and a FIFO-buffered MAC result stream, with a pending scoreboard and starvation stall.
module rf_write_arbiter #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_we_i,
  input  logic [4:0]             core_rd_i,
  input  logic [31:0]            core_wd_i,
  input  logic                   mac_valid_i,
  input  logic [4:0]             mac_rd_i,
  input  logic [31:0]            mac_wd_i,
  output logic                   mac_ready_o,
  output logic                   rf_we_o,
  output logic [4:0]             rf_a3_o,
  output logic [31:0]            rf_wd_o,
  output logic [31:0]            rd_pending_o,
  output logic [$clog2(Depth):0] fifo_count_o,
  output logic                   core_stall_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned SW = $clog2(StarveLimit + 1);
  localparam logic [AW-1:0] PtrOne    = 1;
  localparam logic [AW:0]   CntOne    = 1;
  localparam logic [AW:0]   CntFull   = (AW + 1)'(Depth);
  localparam logic [SW-1:0] StarveOne = 1;
  localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

  logic [4:0]       rd_q [Depth];
  logic [31:0]      wd_q [Depth];
  logic [Depth-1:0] live_q, live_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [31:0]      pend_q, pend_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;

  logic empty, push, pop, core_gnt, squash;

  assign empty        = (count_q == '0);
  assign mac_ready_o  = rst_ni && (count_q < CntFull) && !pend_q[mac_rd_i];
  // Writes to x0 are accepted but never occupy a slot.
  assign push         = mac_valid_i && mac_ready_o && (mac_rd_i != 5'd0);
  assign squash       = core_gnt && pend_q[core_rd_i];
  assign rd_pending_o = pend_q;
  assign fifo_count_o = count_q;
  assign core_stall_o = stall_q;

  always_comb begin
    pop      = 1'b0;
    core_gnt = 1'b0;
    rf_we_o  = 1'b0;
    rf_a3_o  = '0;
    rf_wd_o  = '0;
    if (rst_ni) begin
      if (stall_q && !empty) begin
        pop = 1'b1;
      end else if (core_we_i) begin
        core_gnt = 1'b1;
      end else if (!empty) begin
        pop = 1'b1;
      end
    end
    if (pop) begin
      rf_we_o = live_q[head_q];
      rf_a3_o = rd_q[head_q];
      rf_wd_o = wd_q[head_q];
    end else if (core_gnt) begin
      rf_we_o = (core_rd_i != 5'd0);
      rf_a3_o = core_rd_i;
      rf_wd_o = core_wd_i;
    end
  end

  always_comb begin
    live_d  = live_q;
    pend_d  = pend_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      live_d[head_q] = 1'b0;
      if (live_q[head_q]) pend_d[rd_q[head_q]] = 1'b0;
      head_d = head_q + PtrOne;
    end
    // Pending bits are unique, so at most one live entry matches the core write.
    if (squash) begin
      for (int i = 0; i < Depth; i++) begin
        if (rd_q[i] == core_rd_i) live_d[i] = 1'b0;
      end
      pend_d[core_rd_i] = 1'b0;
    end
    if (push) begin
      live_d[tail_q]   = 1'b1;
      pend_d[mac_rd_i] = 1'b1;
      tail_d           = tail_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end

    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + StarveOne;
    end

    stall_d = stall_q;
    if (count_d == '0) begin
      stall_d = 1'b0;
    end else if (starve_d == StarveMax) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      live_q   <= '0;
      pend_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      live_q   <= live_d;
      pend_q   <= pend_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[tail_q] <= mac_rd_i;
      wd_q[tail_q] <= mac_wd_i;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed check of rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_wd = '0;
  logic        mac_valid = 1'b0;
  logic [4:0]  mac_rd = '0;
  logic [31:0] mac_wd = '0;
  logic        mac_ready, rf_we, core_stall;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rd_pending;
  logic [2:0]  fifo_count;

  rf_write_arbiter #(.Depth(DEPTH), .StarveLimit(LIMIT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .core_we_i   (core_we),
    .core_rd_i   (core_rd),
    .core_wd_i   (core_wd),
    .mac_valid_i (mac_valid),
    .mac_rd_i    (mac_rd),
    .mac_wd_i    (mac_wd),
    .mac_ready_o (mac_ready),
    .rf_we_o     (rf_we),
    .rf_a3_o     (rf_a3),
    .rf_wd_o     (rf_wd),
    .rd_pending_o(rd_pending),
    .fifo_count_o(fifo_count),
    .core_stall_o(core_stall)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port.
  logic [31:0] shadow [32];
  always @(posedge clk) if (rf_we) shadow[rf_a3] <= rf_wd;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          live;
  } ent_t;

  ent_t      q[$];
  bit [31:0] m_pend = '0;
  int        m_starve = 0;
  bit        m_stall = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit cwe, input logic [4:0] crd, input logic [31:0] cwd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] mwd);
    bit          e_ready, pop, cg, e_we, was_empty;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    ent_t        h;
    @(negedge clk);
    rst_n = r; core_we = cwe; core_rd = crd; core_wd = cwd;
    mac_valid = mv; mac_rd = mrd; mac_wd = mwd;
    #1;
    e_ready = r && (q.size() < DEPTH) && !m_pend[mrd];
    pop = 1'b0;
    cg  = 1'b0;
    if (r) begin
      if (m_stall && q.size() > 0) pop = 1'b1;
      else if (cwe)                cg  = 1'b1;
      else if (q.size() > 0)       pop = 1'b1;
    end
    e_we = 1'b0; e_a3 = '0; e_wd = '0;
    if (pop) begin
      e_we = q[0].live; e_a3 = q[0].rd; e_wd = q[0].wd;
    end else if (cg) begin
      e_we = (crd != 0); e_a3 = crd; e_wd = cwd;
    end
    chk("mac_ready", 32'(mac_ready), 32'(e_ready));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_a3", 32'(rf_a3), 32'(e_a3));
    chk("rf_wd", rf_wd, e_wd);
    chk("rd_pending", rd_pending, m_pend);
    chk("fifo_count", 32'(fifo_count), q.size());
    chk("core_stall", 32'(core_stall), 32'(m_stall));
    @(posedge clk);
    if (!r) begin
      q.delete(); m_pend = '0; m_starve = 0; m_stall = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      if (pop) begin
        h = q.pop_front();
        if (h.live) m_pend[h.rd] = 1'b0;
      end
      if (cg && crd != 0 && m_pend[crd]) begin
        foreach (q[i]) if (q[i].rd == crd) q[i].live = 1'b0;
        m_pend[crd] = 1'b0;
      end
      if (mv && e_ready && mrd != 0) begin
        q.push_back('{rd: mrd, wd: mwd, live: 1'b1});
        m_pend[mrd] = 1'b1;
      end
      if (pop || was_empty) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (q.size() == 0) m_stall = 1'b0;
      else if (m_starve == LIMIT) m_stall = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 32'h55, 1, 4, 32'h66);

    // Core-only pass-through, including x0.
    step(1, 1, 5, 32'hA5, 0, 0, 0);
    step(1, 1, 0, 32'h77, 0, 0, 0);

    // MAC drain on idle cycles.
    step(1, 0, 0, 0, 1, 6, 32'h10);
    step(1, 0, 0, 0, 1, 7, 32'h20);
    idle(3);
    chk("x6_value", shadow[6], 32'h10);
    chk("x7_value", shadow[7], 32'h20);

    // Fill to full behind a busy core, then offer a still-pending rd.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 5'(10 + i), 32'(i));
    step(1, 0, 0, 0, 1, 11, 32'hB0);
    step(1, 0, 0, 0, 1, 11, 32'hB1);
    idle(6);

    // Starvation: one entry held off by continuous core writes.
    step(1, 0, 0, 0, 1, 12, 32'hC0);
    for (int i = 0; i < 12; i++) step(1, 1, 3, 32'(i), 0, 0, 0);
    idle(2);

    // WAW squash: core value must survive the stale MAC result.
    step(1, 1, 0, 0, 1, 9, 32'h1);
    step(1, 1, 9, 32'h2, 0, 0, 0);
    idle(2);
    chk("x9_value", shadow[9], 32'h2);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 5'(20 + i), 32'(i));
    step(0, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(49) != 0), ($urandom_range(9) < 6), 5'($urandom_range(15)),
           $urandom(), ($urandom_range(9) < 6), 5'($urandom_range(15)), $urandom());
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
